// File: rtl/reg_file_rd_wr_if.sv
// Write-back / decode / debug signal bundle for the Y86-64 register file.
// The master side is the pipeline (write-back plus decode); the slave side is the register file.
`timescale 1ns/1ps
interface reg_file_rd_wr_if #(
  parameter int DATA_W = 64
);
  logic              wb_en;
  logic [3:0]        dstE;
  logic [DATA_W-1:0] valE;
  logic [3:0]        dstM;
  logic [DATA_W-1:0] valM;
  logic [3:0]        srcA;
  logic [3:0]        srcB;
  logic [DATA_W-1:0] valA;
  logic [DATA_W-1:0] valB;
  logic [3:0]        dbg_idx;
  logic [DATA_W-1:0] dbg_val;
  logic [15:0]       wr_cnt;

  modport master (
    output wb_en, dstE, valE, dstM, valM, srcA, srcB, dbg_idx,
    input  valA, valB, dbg_val, wr_cnt
  );

  modport slave (
    input  wb_en, dstE, valE, dstM, valM, srcA, srcB, dbg_idx,
    output valA, valB, dbg_val, wr_cnt
  );
endinterface

// File: rtl/reg_file_rd_wr.sv
// Y86-64 register file: 15 registers with dual write (E/M) and dual combinational read (A/B).
// ID 0xF is "no register"; the M port wins a same-register collision.
`timescale 1ns/1ps
module reg_file_rd_wr #(
  parameter int              DATA_W   = 64,
  parameter logic [DATA_W-1:0] RSP_INIT = '0,
  parameter bit              BYPASS   = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  reg_file_rd_wr_if.slave bus
);
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  logic [DATA_W-1:0] regs [0:14];
  logic [DATA_W-1:0] dbg_val_q;
  logic [15:0]       wr_cnt_q;

  logic              we_e;
  logic              we_m;
  logic              fwd_ok;
  logic [1:0]        n_wr;
  logic [16:0]       cnt_sum;
  logic [DATA_W-1:0] st_a;
  logic [DATA_W-1:0] st_b;
  logic [DATA_W-1:0] st_dbg;

  assign we_e   = bus.dstE != RNONE;
  assign we_m   = bus.dstM != RNONE;
  assign fwd_ok = BYPASS && bus.wb_en && !rst;

  // A collision on the same register commits once, so the E write is not counted.
  assign n_wr    = {1'b0, we_m} + {1'b0, we_e && !(we_m && (bus.dstE == bus.dstM))};
  assign cnt_sum = {1'b0, wr_cnt_q} + {15'd0, n_wr};

  always_comb begin
    st_a   = '0;
    st_b   = '0;
    st_dbg = '0;
    for (int i = 0; i < 15; i++) begin
      if (bus.srcA == 4'(i))    st_a   = regs[i];
      if (bus.srcB == 4'(i))    st_b   = regs[i];
      if (bus.dbg_idx == 4'(i)) st_dbg = regs[i];
    end
  end

  always_comb begin
    bus.valA = st_a;
    if (bus.srcA == RNONE)                                 bus.valA = '0;
    else if (fwd_ok && we_m && (bus.srcA == bus.dstM))     bus.valA = bus.valM;
    else if (fwd_ok && we_e && (bus.srcA == bus.dstE))     bus.valA = bus.valE;
  end

  always_comb begin
    bus.valB = st_b;
    if (bus.srcB == RNONE)                                 bus.valB = '0;
    else if (fwd_ok && we_m && (bus.srcB == bus.dstM))     bus.valB = bus.valM;
    else if (fwd_ok && we_e && (bus.srcB == bus.dstE))     bus.valB = bus.valE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) begin
        regs[i] <= (4'(i) == RRSP) ? RSP_INIT : '0;
      end
      dbg_val_q <= '0;
      wr_cnt_q  <= '0;
    end else begin
      // st_dbg reads the pre-write contents, so the snapshot never sees this edge's write.
      dbg_val_q <= st_dbg;
      if (bus.wb_en) begin
        for (int i = 0; i < 15; i++) begin
          if (we_m && (bus.dstM == 4'(i)))      regs[i] <= bus.valM;
          else if (we_e && (bus.dstE == 4'(i))) regs[i] <= bus.valE;
        end
        wr_cnt_q <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
      end
    end
  end

  assign bus.dbg_val = dbg_val_q;
  assign bus.wr_cnt  = wr_cnt_q;
endmodule

// File: tb/tb_reg_file_rd_wr.sv
// Directed bench for reg_file_rd_wr: reset, single/dual/colliding writes, stall, bypass,
// debug snapshot, reset during a write and write-counter saturation.
`timescale 1ns/1ps
module tb_reg_file_rd_wr;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  reg_file_rd_wr_if #(.DATA_W(64)) bus ();

  reg_file_rd_wr #(
    .DATA_W   (64),
    .RSP_INIT (64'h100),
    .BYPASS   (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wb_en = 1'b0;
    bus.dstE  = 4'hF;
    bus.valE  = '0;
    bus.dstM  = 4'hF;
    bus.valM  = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    bus.srcA    = 4'hF;
    bus.srcB    = 4'hF;
    bus.dbg_idx = 4'h4;
    edge_step();
    edge_step();
    rst = 1'b0;

    // Reset state
    bus.srcA = 4'h4;
    bus.srcB = 4'h0;
    #1;
    chk("rst_rsp", bus.valA, 64'h100);
    chk("rst_r0", bus.valB, 64'h0);
    chk("rst_cnt", 64'(bus.wr_cnt), 64'h0);
    chk("rst_dbg", bus.dbg_val, 64'h0);
    edge_step();
    chk("dbg_rsp", bus.dbg_val, 64'h100);

    // Single E write with same-cycle bypass
    bus.wb_en = 1'b1;
    bus.dstE  = 4'h3;
    bus.valE  = 64'hDEAD_BEEF;
    bus.srcA  = 4'h3;
    #1;
    chk("single_byp", bus.valA, 64'hDEAD_BEEF);
    edge_step();
    idle();
    #1;
    chk("single_st", bus.valA, 64'hDEAD_BEEF);
    chk("single_cnt", 64'(bus.wr_cnt), 64'd1);

    // E/M collision on %rsp: M wins, counts once
    bus.wb_en = 1'b1;
    bus.dstE  = 4'h4;
    bus.valE  = 64'h8;
    bus.dstM  = 4'h4;
    bus.valM  = 64'h55;
    bus.srcA  = 4'h4;
    bus.srcB  = 4'h4;
    #1;
    chk("coll_bypA", bus.valA, 64'h55);
    chk("coll_bypB", bus.valB, 64'h55);
    edge_step();
    idle();
    #1;
    chk("coll_st", bus.valA, 64'h55);
    chk("coll_cnt", 64'(bus.wr_cnt), 64'd2);

    // Dual write to distinct registers
    bus.wb_en = 1'b1;
    bus.dstE  = 4'h1;
    bus.valE  = 64'd5;
    bus.dstM  = 4'h2;
    bus.valM  = 64'd7;
    bus.srcA  = 4'h1;
    bus.srcB  = 4'h2;
    #1;
    chk("dual_bypA", bus.valA, 64'd5);
    chk("dual_bypB", bus.valB, 64'd7);
    edge_step();
    idle();
    #1;
    chk("dual_stA", bus.valA, 64'd5);
    chk("dual_stB", bus.valB, 64'd7);
    chk("dual_cnt", 64'(bus.wr_cnt), 64'd4);

    // Stall: no write, no bypass
    bus.wb_en = 1'b0;
    bus.dstE  = 4'h5;
    bus.valE  = 64'd9;
    bus.srcA  = 4'h5;
    #1;
    chk("stall_byp", bus.valA, 64'h0);
    edge_step();
    idle();
    #1;
    chk("stall_st", bus.valA, 64'h0);
    chk("stall_cnt", 64'(bus.wr_cnt), 64'd4);

    // Writes to 0xF go nowhere; reads of 0xF are zero
    bus.wb_en   = 1'b1;
    bus.dstE    = 4'hF;
    bus.valE    = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.dstM    = 4'hF;
    bus.valM    = 64'h1234;
    bus.srcA    = 4'hF;
    bus.dbg_idx = 4'h1;
    #1;
    chk("none_rd", bus.valA, 64'h0);
    edge_step();
    chk("none_cnt", 64'(bus.wr_cnt), 64'd4);
    chk("dbg_r1", bus.dbg_val, 64'd5);

    // Debug snapshot returns the pre-write value
    bus.dstE = 4'h1;
    bus.valE = 64'hAA;
    bus.dstM = 4'hF;
    edge_step();
    idle();
    chk("dbg_prewr", bus.dbg_val, 64'd5);
    chk("dbg_cnt", 64'(bus.wr_cnt), 64'd5);
    edge_step();
    chk("dbg_postwr", bus.dbg_val, 64'hAA);
    bus.dbg_idx = 4'hF;
    edge_step();
    chk("dbg_none", bus.dbg_val, 64'h0);

    // Reset together with a write: write discarded, bypass suppressed
    rst       = 1'b1;
    bus.wb_en = 1'b1;
    bus.dstE  = 4'h6;
    bus.valE  = 64'd1;
    bus.dstM  = 4'h1;
    bus.valM  = 64'h77;
    bus.srcA  = 4'h6;
    bus.srcB  = 4'h1;
    bus.dbg_idx = 4'h1;
    #1;
    chk("rstw_nobyp", bus.valB, 64'hAA);
    edge_step();
    rst = 1'b0;
    idle();
    #1;
    chk("rstw_r6", bus.valA, 64'h0);
    chk("rstw_r1", bus.valB, 64'h0);
    chk("rstw_cnt", 64'(bus.wr_cnt), 64'h0);
    chk("rstw_dbg", bus.dbg_val, 64'h0);
    bus.srcA = 4'h4;
    #1;
    chk("rstw_rsp", bus.valA, 64'h100);

    // Counter saturation
    bus.wb_en = 1'b1;
    bus.dstE  = 4'h7;
    bus.valE  = 64'h3;
    for (int i = 0; i < 65534; i++) edge_step();
    chk("sat_fffe", 64'(bus.wr_cnt), 64'hFFFE);
    edge_step();
    chk("sat_ffff", 64'(bus.wr_cnt), 64'hFFFF);
    edge_step();
    edge_step();
    chk("sat_hold", 64'(bus.wr_cnt), 64'hFFFF);
    bus.dstM = 4'h8;
    bus.valM = 64'h4;
    edge_step();
    chk("sat_dual", 64'(bus.wr_cnt), 64'hFFFF);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/reg_file_rd_wr.md
Name: reg_file_rd_wr

Overview:
- Y86-64 register file: the receiving end of the write-back interface and the source end of decode.
- Accepts the dstE/valE and dstM/valM write requests produced by write-back.
- Serves the srcA/srcB operand reads requested by decode.
- Holds the 15 architectural registers (IDs 0x0–0xE). ID 0xF means "no register" on every port.

Parameters:
- DATA_W, 64, register width in bits.
- RSP_INIT, 64'h0, reset value of %rsp (ID 0x4); all other registers reset to 0.
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports; 0 = reads return the stored value only.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- wb_en  input  1  write-back valid; 0 (stall/bubble) suppresses both writes.
- dstE  input  4  E-port destination ID; 0xF = no write.
- valE  input  DATA_W  E-port write data.
- dstM  input  4  M-port destination ID; 0xF = no write.
- valM  input  DATA_W  M-port write data.
- srcA  input  4  read port A ID; 0xF = none.
- srcB  input  4  read port B ID; 0xF = none.
- valA  output  DATA_W  read port A data.
- valB  output  DATA_W  read port B data.
- dbg_idx  input  4  debug snapshot register select.
- dbg_val  output  DATA_W  registered snapshot of regs[dbg_idx].
- wr_cnt  output  16  count of committed register writes (debug).

Behaviour:
- Storage: 15 × DATA_W flops. There is no storage for ID 0xF.
- Reset (rst=1 at a clk edge):
  - regs[0x4] = RSP_INIT; all other registers = 0.
  - dbg_val = 0; wr_cnt = 0.
  - Any write presented in that cycle is discarded.
  - Reset mid-operation has the same effect.
- Write, per clk edge with rst=0 and wb_en=1:
  - dstE != 0xF: regs[dstE] <= valE.
  - dstM != 0xF: regs[dstM] <= valM.
  - dstE == dstM != 0xF: valM wins (popq %rsp semantics). This counts as one write.
- wb_en=0: no register changes and wr_cnt holds. dstE/dstM are ignored.
- wr_cnt increments by the number of distinct registers written that edge (0, 1 or 2). It saturates at 16'hFFFF and does not wrap.
- Read (combinational, zero latency):
  - srcX == 0xF → valX = 0.
  - Otherwise valX = regs[srcX].
- Read with BYPASS=1, checked in priority order when wb_en=1 and rst=0:
  - srcX == dstM != 0xF → valX = valM.
  - else srcX == dstE != 0xF → valX = valE.
  - else stored value.
  - No bypass while rst=1 or wb_en=0.
- Read with BYPASS=0: the new value is visible on the cycle after the write edge.
- Both read ports may address the same register; each port resolves independently.
- dbg_val:
  - Updates every edge to the pre-write stored value of regs[dbg_idx] (one-cycle latency, no bypass).
  - dbg_idx == 0xF → 0.
- Values are full DATA_W. No truncation, sign handling or arithmetic, except wr_cnt.

Test Plan:
- Reset check: pulse rst with RSP_INIT=64'h100, then read srcA=0x4, srcB=0x0. Required: valA=64'h100, valB=0, wr_cnt=0.
- Single write: wb_en=1, dstE=0x3, valE=64'hDEAD_BEEF, dstM=0xF. Next cycle srcA=0x3 → valA=64'hDEAD_BEEF and wr_cnt=1. With BYPASS=1, valA already equals 64'hDEAD_BEEF in the write cycle.
- Collision: dstE=dstM=0x4, valE=64'h8, valM=64'h55. Required: regs[4]=64'h55, wr_cnt +1, and same-cycle bypass on srcA=0x4 returns 64'h55.
- Dual write: dstE=0x1 with valE=5, dstM=0x2 with valM=7. Required: next cycle valA(src 1)=5, valB(src 2)=7, wr_cnt +2.
- Stall and none-ID: wb_en=0 with dstE=0x5, valE=9 → regs[5] unchanged, wr_cnt unchanged. srcA=0xF → valA=0 regardless of any write to 0xF.
- Reset mid-write: rst=1 together with wb_en=1, dstE=0x6, valE=1. Required: regs[6]=0 after the edge and wr_cnt=0. Then 65535 single writes followed by 2 more → wr_cnt stays at 16'hFFFF.
